led_pwm_driver: RTL and testbench

Output stage between the `leds` MMIO register and the board LED pins. It double-buffers the 24-bit LED image so that changes land only at PWM period boundaries. It applies 16-level global brightness PWM and an optional blink gate. It also provides a walking-one self-test mode. CPU configuration arrives through a one-word write port decoded by the MMIO address logic.

---
 rtl/led_pkg.sv | 38 +++
 rtl/led_tick_gen.sv | 33 +++
 rtl/led_pwm_driver.sv | 128 ++++++++++++
 tb/tb_led_pwm_driver.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// rtl/led_pkg.sv - shared types and constants for the LED PWM output stage
package led_pkg;

    localparam int LED_W  = 24;
    localparam int SLOT_W = 4;

    localparam int CFG_BRIGHT_LSB = 0;
    localparam int CFG_BRIGHT_MSB = 3;
    localparam int CFG_BLINK_EN   = 4;
    localparam int CFG_RATE_LSB   = 5;
    localparam int CFG_RATE_MSB   = 6;
    localparam int CFG_TEST_MODE  = 7;

    typedef enum logic {
        NORMAL = 1'b0,
        TEST   = 1'b1
    } led_state_e;

    // Packed MSB-first so the struct overlays cfg_wdata[7:0] bit for bit
    typedef struct packed {
        logic       test_mode;
        logic [1:0] blink_rate;
        logic       blink_en;
        logic [3:0] brightness;
    } led_cfg_t;

    localparam led_cfg_t CFG_RESET = '{
        test_mode:  1'b0,
        blink_rate: 2'b00,
        blink_en:   1'b0,
        brightness: 4'hF
    };

    function automatic logic [LED_W-1:0] onehot(input logic [4:0] pos);
        return LED_W'(1) << pos;
    endfunction

endpackage

// File: rtl/led_tick_gen.sv
// rtl/led_tick_gen.sv - PWM prescaler and slot counter with period boundary strobe
module led_tick_gen
    import led_pkg::*;
#(
    parameter int PWM_DIV = 390
) (
    input  logic              led_clk,
    input  logic              ledrst,
    output logic [SLOT_W-1:0] slot,
    output logic              slot_tick,
    output logic              period_tick
);

    localparam int PRE_W = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;

    logic [PRE_W-1:0] presc;

    assign slot_tick   = (presc == PRE_W'(PWM_DIV - 1));
    assign period_tick = slot_tick && (slot == '1);

    always_ff @(posedge led_clk) begin
        if (ledrst) begin
            presc <= '0;
            slot  <= '0;
        end else if (slot_tick) begin
            presc <= '0;
            slot  <= slot + SLOT_W'(1);
        end else begin
            presc <= presc + PRE_W'(1);
        end
    end

endmodule

// File: rtl/led_pwm_driver.sv
// rtl/led_pwm_driver.sv - double-buffered LED image with brightness PWM, blink and walk test
module led_pwm_driver
    import led_pkg::*;
#(
    parameter int PWM_DIV       = 390,
    parameter int BLINK_PERIODS = 1024,
    parameter int WALK_PERIODS  = 512
) (
    input  logic             led_clk,
    input  logic             ledrst,
    input  logic [LED_W-1:0] led_in,
    input  logic             cfg_we,
    input  logic [15:0]      cfg_wdata,
    output logic [LED_W-1:0] led_pin,
    output logic             frame_start
);

    // Largest half-phase is BLINK_PERIODS << 6 periods
    localparam int BLK_W  = $clog2(BLINK_PERIODS * 64 + 1);
    localparam int WALK_W = (WALK_PERIODS > 1) ? $clog2(WALK_PERIODS) : 1;

    logic [SLOT_W-1:0] slot, slot_nxt;
    logic              slot_tick;
    logic              period_tick;

    led_cfg_t          cfg_q;
    logic [LED_W-1:0]  disp_buf, disp_nxt;
    logic [3:0]        act_bright, bright_nxt;
    led_state_e        state, state_nxt;
    logic [BLK_W-1:0]  blink_cnt, blink_cnt_nxt, blink_limit;
    logic              blink_phase, blink_phase_nxt;
    logic [WALK_W-1:0] walk_cnt, walk_cnt_nxt;
    logic [4:0]        walk_pos, walk_pos_nxt;
    logic [LED_W-1:0]  pattern, pin_nxt;
    logic              pwm_on, blank;
    logic              unused_cfg_hi;

    assign unused_cfg_hi = ^cfg_wdata[15:8];

    led_tick_gen #(
        .PWM_DIV (PWM_DIV)
    ) u_tick (
        .led_clk     (led_clk),
        .ledrst      (ledrst),
        .slot        (slot),
        .slot_tick   (slot_tick),
        .period_tick (period_tick)
    );

    assign slot_nxt    = slot_tick ? slot + SLOT_W'(1) : slot;
    assign blink_limit = BLK_W'(BLINK_PERIODS) << {cfg_q.blink_rate, 1'b0};

    // Output is computed from next-state values so the first pixel of a
    // period lands on the same cycle as frame_start.
    always_comb begin
        disp_nxt        = disp_buf;
        bright_nxt      = act_bright;
        state_nxt       = state;
        blink_cnt_nxt   = blink_cnt;
        blink_phase_nxt = blink_phase;
        walk_cnt_nxt    = walk_cnt;
        walk_pos_nxt    = walk_pos;

        if (period_tick) begin
            disp_nxt   = led_in;
            bright_nxt = cfg_q.brightness;
            state_nxt  = cfg_q.test_mode ? TEST : NORMAL;

            if (blink_cnt == blink_limit - BLK_W'(1)) begin
                blink_cnt_nxt   = '0;
                blink_phase_nxt = ~blink_phase;
            end else begin
                blink_cnt_nxt = blink_cnt + BLK_W'(1);
            end

            if (state_nxt == TEST && state == TEST) begin
                if (walk_cnt == WALK_W'(WALK_PERIODS - 1)) begin
                    walk_cnt_nxt = '0;
                    walk_pos_nxt = (walk_pos == 5'd23) ? 5'd0 : walk_pos + 5'd1;
                end else begin
                    walk_cnt_nxt = walk_cnt + WALK_W'(1);
                end
            end else begin
                walk_cnt_nxt = '0;
                walk_pos_nxt = '0;
            end
        end

        if (!cfg_q.blink_en) begin
            blink_cnt_nxt   = '0;
            blink_phase_nxt = 1'b0;
        end

        pattern = (state_nxt == TEST) ? onehot(walk_pos_nxt) : disp_nxt;
        pwm_on  = (bright_nxt == 4'd15) || (slot_nxt < bright_nxt);
        blank   = (state_nxt == NORMAL) && cfg_q.blink_en && blink_phase_nxt;
        pin_nxt = (pwm_on && !blank) ? pattern : '0;
    end

    always_ff @(posedge led_clk) begin
        if (ledrst) begin
            cfg_q       <= CFG_RESET;
            disp_buf    <= '0;
            act_bright  <= 4'hF;
            state       <= NORMAL;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
            walk_cnt    <= '0;
            walk_pos    <= '0;
            led_pin     <= '0;
            frame_start <= 1'b0;
        end else begin
            if (cfg_we) begin
                cfg_q <= led_cfg_t'(cfg_wdata[7:0]);
            end
            disp_buf    <= disp_nxt;
            act_bright  <= bright_nxt;
            state       <= state_nxt;
            blink_cnt   <= blink_cnt_nxt;
            blink_phase <= blink_phase_nxt;
            walk_cnt    <= walk_cnt_nxt;
            walk_pos    <= walk_pos_nxt;
            led_pin     <= pin_nxt;
            frame_start <= period_tick;
        end
    end

endmodule

// File: tb/tb_led_pwm_driver.sv
// tb/tb_led_pwm_driver.sv - self-checking bench for led_pwm_driver
module tb_led_pwm_driver;

    logic        led_clk = 1'b0;
    logic        ledrst = 1'b1;
    logic [23:0] led_in = '0;
    logic        cfg_we = 1'b0;
    logic [15:0] cfg_wdata = '0;
    logic [23:0] led_pin;
    logic        frame_start;

    int          n_pass = 0;
    int          n_total = 0;
    logic [23:0] exp_q[$];

    always #5 led_clk = ~led_clk;

    led_pwm_driver #(
        .PWM_DIV       (2),
        .BLINK_PERIODS (2),
        .WALK_PERIODS  (1)
    ) dut (
        .led_clk     (led_clk),
        .ledrst      (ledrst),
        .led_in      (led_in),
        .cfg_we      (cfg_we),
        .cfg_wdata   (cfg_wdata),
        .led_pin     (led_pin),
        .frame_start (frame_start)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step();
        @(posedge led_clk);
        #1;
    endtask

    task automatic cfg_write(input logic [15:0] d);
        cfg_wdata = d;
        cfg_we    = 1'b1;
        step();
        cfg_we    = 1'b0;
        cfg_wdata = '0;
    endtask

    task automatic wait_frame(input string tag);
        int n = 0;
        while (frame_start !== 1'b1 && n < 80) begin
            step();
            n++;
        end
        n_total++;
        if (frame_start !== 1'b1) $display("FAIL %s_wait: frame_start=%b after %0d cycles, required 1", tag, frame_start, n);
        else n_pass++;
    endtask

    // Expected led_pin for each of the 32 cycles of a period (2 cycles per slot)
    task automatic push_period(input logic [23:0] pat, input int bright, input bit off);
        for (int i = 0; i < 32; i++)
            exp_q.push_back((!off && (bright == 15 || i / 2 < bright)) ? pat : 24'h0);
    endtask

    task automatic test_reset();
        logic [23:0] e;
        ledrst = 1'b1;
        led_in = 24'hA5A5A5;
        step();
        step();
        n_total += 2;
        if (led_pin !== 24'h0) $display("FAIL reset_pin: led_pin=%h required 000000", led_pin); else n_pass++;
        if (frame_start !== 1'b0) $display("FAIL reset_frame: frame_start=%b required 0", frame_start); else n_pass++;
        ledrst = 1'b0;
        for (int i = 1; i <= 32; i++) begin
            step();
            n_total++;
            if (frame_start !== 1'(i == 32)) $display("FAIL reset_first_boundary: cycle %0d frame_start=%b required %b", i, frame_start, (i == 32));
            else n_pass++;
            if (i < 32) begin
                n_total++;
                if (led_pin !== 24'h0) $display("FAIL reset_pre_boundary: cycle %0d led_pin=%h required 000000", i, led_pin);
                else n_pass++;
            end
        end
        push_period(24'hA5A5A5, 15, 1'b0);
        for (int i = 0; i < 32; i++) begin
            e = exp_q.pop_front();
            n_total += 2;
            if (led_pin !== e) $display("FAIL reset_image: cycle %0d led_pin=%h required %h", i, led_pin, e); else n_pass++;
            if (frame_start !== 1'(i == 0)) $display("FAIL reset_pulse: cycle %0d frame_start=%b required %b", i, frame_start, (i == 0));
            else n_pass++;
            step();
        end
    endtask

    task automatic test_brightness();
        int          bl[4];
        logic [23:0] e;
        bl = '{4, 0, 1, 14};
        led_in = 24'hFFFFFF;
        for (int b = 0; b < 4; b++) begin
            cfg_write(16'hAB00 | 16'(bl[b]));
            wait_frame("bright");
            push_period(24'hFFFFFF, bl[b], 1'b0);
            for (int i = 0; i < 32; i++) begin
                e = exp_q.pop_front();
                n_total += 2;
                if (led_pin !== e) $display("FAIL bright_%0d: cycle %0d led_pin=%h required %h", bl[b], i, led_pin, e); else n_pass++;
                if (frame_start !== 1'(i == 0)) $display("FAIL bright_pulse: cycle %0d frame_start=%b required %b", i, frame_start, (i == 0));
                else n_pass++;
                step();
            end
        end
    endtask

    task automatic test_glitch();
        logic [23:0] prev;
        logic [23:0] e;
        cfg_write(16'h000F);
        wait_frame("glitch");
        prev = 24'hFFFFFF;
        for (int p = 0; p < 3; p++) begin
            push_period(prev, 15, 1'b0);
            for (int i = 0; i < 32; i++) begin
                if (i % 3 == 0) led_in = 24'($urandom);
                e = exp_q.pop_front();
                n_total++;
                if (led_pin !== e) $display("FAIL glitch: period %0d cycle %0d led_pin=%h required %h", p, i, led_pin, e); else n_pass++;
                step();
            end
            prev = led_in;
        end
    endtask

    task automatic test_blink();
        bit          on_tbl[8];
        logic [23:0] e;
        on_tbl = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        led_in = 24'h000001;
        cfg_write(16'h001F);
        wait_frame("blink");
        for (int p = 0; p < 8; p++) begin
            push_period(24'h000001, 15, !on_tbl[p]);
            for (int i = 0; i < 32; i++) begin
                e = exp_q.pop_front();
                n_total++;
                if (led_pin !== e) $display("FAIL blink: period %0d cycle %0d led_pin=%h required %h", p, i, led_pin, e); else n_pass++;
                step();
            end
        end
        cfg_write(16'h000F);
        wait_frame("blink_off");
        push_period(24'h000001, 15, 1'b0);
        for (int i = 0; i < 32; i++) begin
            e = exp_q.pop_front();
            n_total++;
            if (led_pin !== e) $display("FAIL blink_cleared: cycle %0d led_pin=%h required %h", i, led_pin, e); else n_pass++;
            step();
        end
    endtask

    task automatic test_walk();
        logic [23:0] e;
        logic [23:0] one;
        led_in = 24'h00F00F;
        cfg_write(16'h008F);
        wait_frame("walk");
        for (int k = 0; k < 25; k++) begin
            one = 24'h000001 << (k % 24);
            push_period(one, 15, 1'b0);
            for (int i = 0; i < 32; i++) begin
                e = exp_q.pop_front();
                n_total++;
                if (led_pin !== e) $display("FAIL walk: step %0d cycle %0d led_pin=%h required %h", k, i, led_pin, e); else n_pass++;
                step();
            end
        end
        // Land the exit write exactly on the boundary edge: it must be deferred
        for (int i = 0; i < 31; i++) step();
        cfg_wdata = 16'h000F;
        cfg_we    = 1'b1;
        step();
        cfg_we    = 1'b0;
        push_period(24'h000004, 15, 1'b0);
        push_period(24'h00F00F, 15, 1'b0);
        for (int i = 0; i < 64; i++) begin
            e = exp_q.pop_front();
            n_total += 2;
            if (led_pin !== e) $display("FAIL walk_deferred: cycle %0d led_pin=%h required %h", i, led_pin, e); else n_pass++;
            if (frame_start !== 1'(i % 32 == 0)) $display("FAIL walk_pulse: cycle %0d frame_start=%b required %b", i, frame_start, (i % 32 == 0));
            else n_pass++;
            step();
        end
    endtask

    task automatic test_reset_mid();
        logic [23:0] e;
        cfg_write(16'h009F);
        wait_frame("rst_mid");
        for (int i = 0; i < 10; i++) step();
        n_total++;
        if (led_pin !== 24'h000001) $display("FAIL rst_mid_before: led_pin=%h required 000001", led_pin); else n_pass++;
        ledrst = 1'b1;
        led_in = 24'h123456;
        step();
        n_total += 2;
        if (led_pin !== 24'h0) $display("FAIL rst_mid_pin: led_pin=%h required 000000", led_pin); else n_pass++;
        if (frame_start !== 1'b0) $display("FAIL rst_mid_frame: frame_start=%b required 0", frame_start); else n_pass++;
        ledrst = 1'b0;
        for (int i = 1; i <= 32; i++) begin
            step();
            n_total++;
            if (frame_start !== 1'(i == 32)) $display("FAIL rst_mid_boundary: cycle %0d frame_start=%b required %b", i, frame_start, (i == 32));
            else n_pass++;
            if (i < 32) begin
                n_total++;
                if (led_pin !== 24'h0) $display("FAIL rst_mid_pre: cycle %0d led_pin=%h required 000000", i, led_pin);
                else n_pass++;
            end
        end
        push_period(24'h123456, 15, 1'b0);
        push_period(24'h123456, 15, 1'b0);
        for (int i = 0; i < 64; i++) begin
            e = exp_q.pop_front();
            n_total++;
            if (led_pin !== e) $display("FAIL rst_mid_normal: cycle %0d led_pin=%h required %h", i, led_pin, e); else n_pass++;
            step();
        end
    endtask

    initial begin
        test_reset();
        test_brightness();
        test_glitch();
        test_blink();
        test_walk();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
